// File: rtl/ebus_diag_pkg.sv
// Shared constants and enums for the EBUS DIAG read path.
// Select codes name the data-path registers in DIAG read order.
package ebus_diag_pkg;

    localparam logic [6:0] DIAG_READ_EDP = 7'o120;
    localparam int         CNT_W         = 8;

    typedef enum logic [2:0] {
        SEL_AR  = 3'd0,
        SEL_BR  = 3'd1,
        SEL_MQ  = 3'd2,
        SEL_FM  = 3'd3,
        SEL_BRX = 3'd4,
        SEL_ARX = 3'd5,
        SEL_ADX = 3'd6,
        SEL_AD  = 3'd7
    } diag_sel_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_SETTLE,
        ST_HOLD,
        ST_GAP
    } reader_state_e;

endpackage

// File: rtl/diag_settle_counter.sv
// Loadable up-counter with a terminal-count flag.
// It is shared by the strobe-settle and inter-read gap timing.
module diag_settle_counter
    import ebus_diag_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] terminal_i,
    output logic             done_o
);

    logic [WIDTH-1:0] count_q;

    // A load always restarts at 1: the load cycle itself counts as the first one.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= WIDTH'(1);
        end else if (enable_i) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign done_o = (count_q == terminal_i);

endmodule

// File: rtl/ebus_diag_reader.sv
// EBUS DIAG read sequencer: issues function 12X, strobes, samples EBUS.data.
// It returns each word over a valid/ready handshake, optionally scanning selects 0..7.
module ebus_diag_reader
    import ebus_diag_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int GAP_CYCLES    = 1
) (
    input  logic        eboxClk,
    input  logic        eboxReset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic [2:0]  reqSel,
    input  logic        reqScan,
    input  logic [0:35] ebusData,
    output logic [0:6]  diagFunc,
    output logic        diagReadFunc12X,
    output logic        rspValid,
    input  logic        rspReady,
    output logic [2:0]  rspSel,
    output logic [0:35] rspData,
    output logic        rspParity,
    output logic        rspLast,
    output logic        busy
);

    reader_state_e state_q, state_d;
    logic [2:0]    sel_q, sel_d;
    logic          scan_q, scan_d;
    logic [0:6]    diagFunc_q, diagFunc_d;
    logic          strobe_q, strobe_d;
    logic          reqReady_q;
    logic          rspValid_q, rspValid_d;
    logic [0:35]   rspData_q, rspData_d;
    logic [2:0]    rspSel_q, rspSel_d;
    logic          rspParity_q, rspParity_d;
    logic          rspLast_q, rspLast_d;

    logic             cntLoad, cntEnable, cntDone;
    logic [CNT_W-1:0] cntTerminal;

    diag_settle_counter #(.WIDTH(CNT_W)) u_counter (
        .clk_i      (eboxClk),
        .reset_i    (eboxReset),
        .load_i     (cntLoad),
        .enable_i   (cntEnable),
        .terminal_i (cntTerminal),
        .done_o     (cntDone)
    );

    // Outputs are registered, so the strobe rises one edge after STROBE is entered,
    // a full cycle after diagFunc settled.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        scan_d      = scan_q;
        diagFunc_d  = diagFunc_q;
        strobe_d    = 1'b0;
        rspValid_d  = rspValid_q;
        rspData_d   = rspData_q;
        rspSel_d    = rspSel_q;
        rspParity_d = rspParity_q;
        rspLast_d   = rspLast_q;
        cntLoad     = 1'b0;
        cntEnable   = 1'b0;
        cntTerminal = CNT_W'(SETTLE_CYCLES);

        case (state_q)
            ST_IDLE: begin
                if (reqValid && reqReady_q) begin
                    sel_d   = reqScan ? SEL_AR : reqSel;
                    scan_d  = reqScan;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                diagFunc_d = DIAG_READ_EDP | {4'b0000, sel_q};
                state_d    = ST_STROBE;
            end
            ST_STROBE: begin
                strobe_d = 1'b1;
                cntLoad  = 1'b1;
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cntDone) begin
                    rspValid_d  = 1'b1;
                    rspData_d   = ebusData;
                    rspSel_d    = sel_q;
                    rspParity_d = ^ebusData;
                    rspLast_d   = ~scan_q | (sel_q == SEL_AD);
                    state_d     = ST_HOLD;
                end else begin
                    strobe_d  = 1'b1;
                    cntEnable = 1'b1;
                end
            end
            ST_HOLD: begin
                if (rspValid_q && rspReady) begin
                    rspValid_d = 1'b0;
                    if (rspLast_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        sel_d = sel_q + 3'd1;
                        if (GAP_CYCLES == 0) begin
                            state_d = ST_SETUP;
                        end else begin
                            cntLoad = 1'b1;
                            state_d = ST_GAP;
                        end
                    end
                end
            end
            ST_GAP: begin
                cntTerminal = CNT_W'(GAP_CYCLES);
                if (cntDone) begin
                    state_d = ST_SETUP;
                end else begin
                    cntEnable = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge eboxClk) begin
        if (eboxReset) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            scan_q      <= 1'b0;
            diagFunc_q  <= '0;
            strobe_q    <= 1'b0;
            reqReady_q  <= 1'b1;
            rspValid_q  <= 1'b0;
            rspData_q   <= '0;
            rspSel_q    <= '0;
            rspParity_q <= 1'b0;
            rspLast_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            scan_q      <= scan_d;
            diagFunc_q  <= diagFunc_d;
            strobe_q    <= strobe_d;
            reqReady_q  <= (state_d == ST_IDLE);
            rspValid_q  <= rspValid_d;
            rspData_q   <= rspData_d;
            rspSel_q    <= rspSel_d;
            rspParity_q <= rspParity_d;
            rspLast_q   <= rspLast_d;
        end
    end

    assign reqReady        = reqReady_q;
    assign diagFunc        = diagFunc_q;
    assign diagReadFunc12X = strobe_q;
    assign rspValid        = rspValid_q;
    assign rspData         = rspData_q;
    assign rspSel          = rspSel_q;
    assign rspParity       = rspParity_q;
    assign rspLast         = rspLast_q;
    assign busy            = (state_q != ST_IDLE);

endmodule
